// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
// Operations are granted round-robin, launched from registered operands,
// and the captured result is returned to the owner with a valid/ready handshake.
// Build option: define ALU_ARBITER_FIXED_PRIORITY_EN to make requester 0
// win every tie; otherwise ties alternate via last_grant.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data1,
  input  logic [WIDTH-1:0] req0_data2,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data1,
  input  logic [WIDTH-1:0] req1_data2,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [OPW-1:0]   op_reg;
  logic [WIDTH-1:0] result_q;
  logic             owner;
  logic             grant0;
  logic             grant1;
  logic             resp_done;
`ifndef ALU_ARBITER_FIXED_PRIORITY_EN
  logic             last_grant;
`endif

  // Pick the winner among the valid requesters (only meaningful in IDLE).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      // The requester that did not go last gets the tie.
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
`endif
  end

  assign req0_ready  = (state == IDLE) & grant0;
  assign req1_ready  = (state == IDLE) & grant1;
  assign resp_done   = (state == RESP) & (owner ? resp1_ready : resp0_ready);

  // ALU is fed only from the registered operands, so it holds steady
  // outside EXEC and never sees the raw requester buses.
  assign alu_data1   = a_reg;
  assign alu_data2   = b_reg;
  assign alu_op      = op_reg;
  assign resp_result = result_q;

  // Main FSM: accept, execute for one cycle, hold result until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      result_q    <= '0;
      owner       <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIORITY_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            a_reg  <= req0_data1;
            b_reg  <= req0_data2;
            op_reg <= req0_op;
            owner  <= 1'b0;
            busy   <= 1'b1;
            state  <= EXEC;
          end else if (req1_ready) begin
            a_reg  <= req1_data1;
            b_reg  <= req1_data2;
            op_reg <= req1_op;
            owner  <= 1'b1;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          resp0_valid <= ~owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          // The non-owner's resp_ready plays no part here.
          if (resp_done) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIORITY_EN
            last_grant  <= owner;
`endif
            state       <= IDLE;
          end
        end
        default: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized bench for alu_arbiter, checked
// against a transaction-level reference model (in-flight flag + age count).
// Honours ALU_ARBITER_FIXED_PRIORITY_EN in the same way as the design.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [15:0] resp_result, alu_data1, alu_data2, alu_result;
  logic [2:0]  alu_op;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Bench-side ALU: 000 add, 001 or, 010 sub, 011 xor, 100 mul, 101 and,
  // 110 shift left, 111 pass data1.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a | b;
      3'd2:    return a - b;
      3'd3:    return a ^ b;
      3'd4:    return p[15:0];
      3'd5:    return a & b;
      3'd6:    return a << b[3:0];
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_data1, alu_data2, alu_op);

  alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation, described by its age.
  bit          m_busy;
  int          m_age;
  int          m_owner;
  int          m_last;
  logic [15:0] m_a, m_b, m_res;
  logic [2:0]  m_op;
  int          gq[$];
  logic [15:0] rq[$];
  logic [15:0] obs_result;
  logic        obs_r0v, obs_r1v, obs_r0rdy;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0;
  endtask

  // One clock: check outputs on the falling edge, then advance the model.
  task automatic step();
    int w;
    bit rv, hs, done;
    @(negedge clk);
    w = -1;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
        w = 0;
`else
        w = (m_last == 0) ? 1 : 0;
`endif
      end else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
    end
    rv = m_busy && (m_age >= 1);
    check("req0_ready", 32'(req0_ready), 32'(w == 0));
    check("req1_ready", 32'(req1_ready), 32'(w == 1));
    check("busy", 32'(busy), 32'(m_busy));
    check("resp0_valid", 32'(resp0_valid), 32'(rv && m_owner == 0));
    check("resp1_valid", 32'(resp1_valid), 32'(rv && m_owner == 1));
    if (rv) check("resp_result", 32'(resp_result), 32'(m_res));
    check("alu_data1", 32'(alu_data1), 32'(m_a));
    check("alu_data2", 32'(alu_data2), 32'(m_b));
    check("alu_op", 32'(alu_op), 32'(m_op));
    obs_result = resp_result;
    obs_r0v    = resp0_valid;
    obs_r1v    = resp1_valid;
    obs_r0rdy  = req0_ready;
    hs   = (w >= 0);
    done = rv && ((m_owner == 1) ? resp1_ready : resp0_ready);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (hs) begin
      m_busy = 1; m_age = 0; m_owner = w;
      m_a  = (w == 0) ? req0_data1 : req1_data1;
      m_b  = (w == 0) ? req0_data2 : req1_data2;
      m_op = (w == 0) ? req0_op : req1_op;
      m_res = alu_f(m_a, m_b, m_op);
      gq.push_back(w);
    end else if (m_busy) begin
      if (done) begin
        m_busy = 0; m_last = m_owner;
        rq.push_back(m_res);
      end else if (m_age < 1000) begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_data1 = '0; req0_data2 = '0; req0_op = '0;
    req1_data1 = '0; req1_data2 = '0; req1_op = '0;
    resp0_ready = 1; resp1_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 0;
    gq.delete();
    rq.delete();
  endtask

  initial begin
    bit saw_r1v;
    int k;
    idle_inputs();
    do_reset();
    // Reset values
    step();

    // Single request from requester 0
    req0_valid = 1; req0_data1 = 16'd5; req0_data2 = 16'd3; req0_op = 3'b000;
    step();
    check("t2_req0_ready", 32'(obs_r0rdy), 32'd1);
    req0_valid = 0;
    step();
    step();
    check("t2_resp0_valid", 32'(obs_r0v), 32'd1);
    check("t2_result", 32'(obs_result), 32'd8);
    check("t2_resp1_valid", 32'(obs_r1v), 32'd0);
    step();

    // Both held valid, response consumed immediately
    do_reset();
    req0_valid = 1; req0_data1 = 16'd10; req0_data2 = 16'd4; req0_op = 3'b010;
    req1_valid = 1; req1_data1 = 16'h0100; req1_data2 = 16'h0100; req1_op = 3'b100;
    k = 0;
    while (rq.size() < 4 && k < 40) begin step(); k++; end
    req0_valid = 0; req1_valid = 0;
    check("t3_ops_done", 32'(rq.size()), 32'd4);
    if (gq.size() >= 4 && rq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
        check("t3_grant", 32'(gq[i]), 32'd0);
        check("t3_result", 32'(rq[i]), 32'd6);
`else
        check("t3_grant", 32'(gq[i]), 32'(i % 2));
        check("t3_result", 32'(rq[i]), (i % 2 == 0) ? 32'd6 : 32'd0);
`endif
      end
    end
    step();

    // Backpressure on requester 1 while requester 0 waits
    do_reset();
    req1_valid = 1; req1_data1 = 16'd1; req1_data2 = 16'd4; req1_op = 3'b110;
    resp1_ready = 0;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_data1 = 16'd1; req0_data2 = 16'd1; req0_op = 3'b000;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_resp1_hold", 32'(obs_r1v), 32'd1);
      check("t4_result_hold", 32'(obs_result), 32'h0010);
      check("t4_req0_blocked", 32'(obs_r0rdy), 32'd0);
    end
    resp1_ready = 1;
    step();
    check("t4_release", 32'(rq.size()), 32'd1);
    req0_valid = 0;
    repeat (4) step();

    // Reset during EXEC discards the operation
    do_reset();
    req0_valid = 1; req0_data1 = 16'd7; req0_data2 = 16'd2; req0_op = 3'b000;
    step();
    req0_valid = 0;
    reset = 1;
    step();
    reset = 0;
    saw_r1v = 0;
    step();
    check("t5_no_resp0", 32'(obs_r0v), 32'd0);
    req1_valid = 1; req1_data1 = 16'd9; req1_data2 = 16'd9; req1_op = 3'b101;
    step();
    req1_valid = 0;
    step();
    step();
    check("t5_resp1_valid", 32'(obs_r1v), 32'd1);
    check("t5_result", 32'(obs_result), 32'd9);
    step();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      req0_valid  = ($urandom_range(0, 2) != 0);
      req1_valid  = ($urandom_range(0, 2) != 0);
      req0_data1  = 16'($urandom); req0_data2 = 16'($urandom); req0_op = 3'($urandom);
      req1_data1  = 16'($urandom); req1_data2 = 16'($urandom); req1_op = 3'($urandom);
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
